countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Game countdown timer that produces the 10-bit binary seconds value consumed by the three-digit seven-segment timer display.
- Derives a 1 s tick from the system clock.
- Supports load, start, pause/resume and expiry, and signals expiry to the game control logic.
- Sits between game control (start/pause/load) and the timer display decoder.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICKS_PER_SEC, CLK_HZ, clock cycles per decrement. Benches override it to a small value. Minimum legal value is 2.
- START_VALUE, 60, seconds loaded at reset. Must be ≤ 999.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- load  input  1  single-cycle pulse; load load_value.
- load_value  input  10  seconds to load; values > 999 clamp to 999.
- start  input  1  single-cycle pulse; begin or resume counting.
- pause  input  1  level; while high, counting is suspended.
- timer  output  10  current remaining seconds, 0..999, registered.
- running  output  1  high in RUN state.
- expired  output  1  one-cycle pulse when timer reaches 0 by counting.
- done  output  1  level, high in DONE state.

Behaviour:
- Decided interface facts:
  - One clock, clk.
  - Reset rst is synchronous and active-low: sampled only on the rising clk edge; rst==0 overrides all other inputs.
- Reset values:
  - timer=START_VALUE, running=0, expired=0, done=0.
  - State IDLE; prescaler count=0.
- Registered prescaler:
  - pcnt counts 0..TICKS_PER_SEC-1, advancing only in RUN with pause==0.
  - At terminal count, pcnt wraps to 0 and tick is asserted internally for that cycle.
  - pcnt clears to 0 on load, on start from IDLE/DONE, and on reset.
  - pcnt holds in PAUSED.
- States: IDLE, RUN, PAUSED, DONE.
  - IDLE: start & timer!=0 -> RUN. start & timer==0 -> DONE, with no expired pulse.
  - RUN: pause==1 -> PAUSED, the same cycle pause is sampled. tick with timer>1 -> timer-1. tick with timer==1 -> timer=0, state DONE, expired=1 for exactly one cycle.
  - PAUSED: pause==0 & start -> RUN with pcnt preserved. pause==0 without start stays PAUSED.
  - DONE: start is ignored; stays until load or reset.
- Input priority within one cycle: rst > load > pause > start > tick.
  - load in any state: timer=min(load_value,999), pcnt=0, state IDLE, expired=0.
  - A load coincident with the final tick suppresses expiry.
  - start with pause==1 in IDLE: state goes to PAUSED (armed), not RUN.
- Outputs are registered.
  - running and done reflect the state register, updated the cycle after the causing input.
  - timer updates the cycle after the tick or load edge.
- Arithmetic:
  - timer never underflows below 0 and never exceeds 999.
  - Decrement is by exactly 1 per tick.
  - pcnt width is clog2(TICKS_PER_SEC).
- Reset mid-count behaves identically to power-on reset:
  - timer returns to START_VALUE.
  - No expired pulse is generated.

Test Plan:
- TICKS_PER_SEC=4, START_VALUE=3. Release reset, pulse start -> running=1 next cycle. timer goes 3->2->1->0 at 4-cycle intervals. expired is high for exactly 1 cycle coincident with timer becoming 0. done=1, running=0 afterwards.
- Load load_value=1023 -> timer=999 next cycle, state IDLE. Load 0 then start -> done=1, expired never asserted.
- Running from 3: raise pause after 2 prescaler cycles and hold 10 cycles -> timer frozen, running=0. Drop pause and pulse start -> next decrement occurs after the 2 remaining cycles.
- Running with timer==1: pulse load=5 on the cycle of the final tick -> timer=5, state IDLE, no expired pulse.
- Mid-count at timer=2: assert rst low for 1 cycle -> timer=3, running=0, done=0, expired=0. start in DONE ignored until load.
- Simultaneous start and pause in IDLE -> PAUSED, running=0, timer unchanged. Release pause and pulse start -> RUN.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle between game control (master) and the countdown timer (slave).
interface countdown_timer_if;
    logic       load;
    logic [9:0] load_value;
    logic       start;
    logic       pause;
    logic [9:0] timer;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output load, load_value, start, pause,
        input  timer, running, expired, done
    );

    modport slave (
        input  load, load_value, start, pause,
        output timer, running, expired, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Game countdown timer: seconds counter (0..999) decremented by a prescaled 1 s tick,
// with load, start, pause/resume and a one-cycle expiry pulse.
module countdown_timer #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICKS_PER_SEC = CLK_HZ,
    parameter int START_VALUE   = 60
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);

    localparam int              PCNT_W     = $clog2(TICKS_PER_SEC);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICKS_PER_SEC - 1);
    localparam logic [9:0]      TIMER_MAX  = 10'd999;
    localparam logic [9:0]      START_INIT = 10'(START_VALUE);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t            state_reg;
    logic [PCNT_W-1:0] pcnt_reg;
    logic [9:0]        timer_reg;
    logic              running_reg;
    logic              expired_reg;
    logic              done_reg;

    logic [9:0] load_clamped;
    logic       tick;

    assign load_clamped = (bus.load_value > TIMER_MAX) ? TIMER_MAX : bus.load_value;
    assign tick         = (pcnt_reg == PCNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pcnt_reg    <= '0;
            timer_reg   <= START_INIT;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else if (bus.load) begin
            // load outranks everything else, including a coincident final tick
            state_reg   <= IDLE;
            pcnt_reg    <= '0;
            timer_reg   <= load_clamped;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            expired_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        pcnt_reg <= '0;
                        if (bus.pause) begin
                            state_reg <= PAUSED;
                        end else if (timer_reg != 10'd0) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_reg   <= PAUSED;
                        running_reg <= 1'b0;
                    end else if (tick) begin
                        pcnt_reg <= '0;
                        if (timer_reg > 10'd1) begin
                            timer_reg <= timer_reg - 10'd1;
                        end else begin
                            timer_reg   <= 10'd0;
                            state_reg   <= DONE;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            expired_reg <= (timer_reg == 10'd1);
                        end
                    end else begin
                        pcnt_reg <= pcnt_reg + 1'b1;
                    end
                end
                PAUSED: begin
                    // pcnt is left untouched so the partial second resumes where it stopped
                    if (!bus.pause && bus.start) begin
                        if (timer_reg != 10'd0) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.timer   = timer_reg;
    assign bus.running = running_reg;
    assign bus.expired = expired_reg;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer (4-cycle seconds, start value 3) with a scoreboard queue.
module tb_countdown_timer;

    logic clk;
    logic rst;

    countdown_timer_if bus ();

    countdown_timer #(
        .CLK_HZ        (4),
        .TICKS_PER_SEC (4),
        .START_VALUE   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       load;
        logic [9:0] lv;
        logic       start;
        logic       pause;
        int         cycles;
        logic [9:0] timer;
        logic       running;
        logic       expired;
        logic       done;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[40];

    int checks   = 0;
    int failures = 0;
    int expired_count = 0;

    always @(posedge clk) begin
        if (rst && bus.expired) expired_count = expired_count + 1;
    end

    function automatic vec_t mk(input logic r, input logic ld, input int lv, input logic st,
                                input logic pa, input int cyc, input int t, input logic ru,
                                input logic ex, input logic dn);
        vec_t v;
        v.rst = r; v.load = ld; v.lv = 10'(lv); v.start = st; v.pause = pa;
        v.cycles = cyc; v.timer = 10'(t); v.running = ru; v.expired = ex; v.done = dn;
        return v;
    endfunction

    task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step %0d %s: got %b expected %b", idx, name, act, exp);
        end
    endtask

    // Drive one step: pulses for the first cycle, levels for all cycles, then compare.
    task automatic run_step(input int idx, input vec_t v);
        vec_t e;
        rst            = v.rst;
        bus.load       = v.load;
        bus.load_value = v.lv;
        bus.start      = v.start;
        bus.pause      = v.pause;
        sb_q.push_back(v);
        repeat (v.cycles) begin
            @(posedge clk);
            #1;
            bus.load  = 1'b0;
            bus.start = 1'b0;
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.timer !== e.timer) begin
            failures++;
            $display("FAIL step %0d timer: got %0d expected %0d", idx, bus.timer, e.timer);
        end
        check_bit("running", idx, bus.running, e.running);
        check_bit("expired", idx, bus.expired, e.expired);
        check_bit("done",    idx, bus.done,    e.done);
        $display("step %0d: rst=%b load=%b lv=%0d start=%b pause=%b cyc=%0d -> timer=%0d run=%b exp=%b done=%b",
                 idx, v.rst, v.load, v.lv, v.start, v.pause, v.cycles,
                 bus.timer, bus.running, bus.expired, bus.done);
    endtask

    task automatic check_expired_count(input string name, input int exp);
        checks++;
        if (expired_count != exp) begin
            failures++;
            $display("FAIL %s expired pulse count: got %0d expected %0d", name, expired_count, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0; bus.pause = 1'b0;

        //              rst ld  lv    st  pa  cyc  timer run exp done
        vecs[0]  = mk(1'b0,1'b0,0,   1'b0,1'b0, 2,  3,  1'b0,1'b0,1'b0); // reset state
        vecs[1]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  3,  1'b0,1'b0,1'b0);
        vecs[2]  = mk(1'b1,1'b0,0,   1'b1,1'b0, 1,  3,  1'b1,1'b0,1'b0); // start -> running
        vecs[3]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 3,  3,  1'b1,1'b0,1'b0);
        vecs[4]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  2,  1'b1,1'b0,1'b0); // 4th cycle tick
        vecs[5]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 3,  2,  1'b1,1'b0,1'b0);
        vecs[6]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  1,  1'b1,1'b0,1'b0);
        vecs[7]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 3,  1,  1'b1,1'b0,1'b0);
        vecs[8]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  0,  1'b0,1'b1,1'b1); // expiry
        vecs[9]  = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  0,  1'b0,1'b0,1'b1); // pulse is 1 cycle
        vecs[10] = mk(1'b1,1'b0,0,   1'b1,1'b0, 3,  0,  1'b0,1'b0,1'b1); // start in DONE ignored
        vecs[11] = mk(1'b1,1'b1,1023,1'b0,1'b0, 1,  999,1'b0,1'b0,1'b0); // clamp
        vecs[12] = mk(1'b1,1'b1,0,   1'b0,1'b0, 1,  0,  1'b0,1'b0,1'b0);
        vecs[13] = mk(1'b1,1'b0,0,   1'b1,1'b0, 2,  0,  1'b0,1'b0,1'b1); // start at 0 -> DONE
        vecs[14] = mk(1'b1,1'b1,3,   1'b0,1'b0, 1,  3,  1'b0,1'b0,1'b0);
        vecs[15] = mk(1'b1,1'b0,0,   1'b1,1'b0, 1,  3,  1'b1,1'b0,1'b0);
        vecs[16] = mk(1'b1,1'b0,0,   1'b0,1'b0, 2,  3,  1'b1,1'b0,1'b0); // pcnt now 2
        vecs[17] = mk(1'b1,1'b0,0,   1'b0,1'b1, 1,  3,  1'b0,1'b0,1'b0); // pause
        vecs[18] = mk(1'b1,1'b0,0,   1'b0,1'b1, 10, 3,  1'b0,1'b0,1'b0); // frozen
        vecs[19] = mk(1'b1,1'b0,0,   1'b0,1'b0, 2,  3,  1'b0,1'b0,1'b0); // no start: stays paused
        vecs[20] = mk(1'b1,1'b0,0,   1'b1,1'b0, 1,  3,  1'b1,1'b0,1'b0); // resume
        vecs[21] = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  3,  1'b1,1'b0,1'b0);
        vecs[22] = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  2,  1'b1,1'b0,1'b0); // 2 remaining cycles
        vecs[23] = mk(1'b1,1'b0,0,   1'b0,1'b0, 3,  2,  1'b1,1'b0,1'b0);
        vecs[24] = mk(1'b1,1'b0,0,   1'b0,1'b0, 1,  1,  1'b1,1'b0,1'b0);
        vecs[25] = mk(1'b1,1'b0,0,   1'b0,1'b0, 3,  1,  1'b1,1'b0,1'b0); // final tick is next
        vecs[26] = mk(1'b1,1'b1,5,   1'b0,1'b0, 1,  5,  1'b0,1'b0,1'b0); // load beats tick
        vecs[27] = mk(1'b1,1'b0,0,   1'b0,1'b0, 2,  5,  1'b0,1'b0,1'b0);

        for (int i = 0; i < 28; i++) run_step(i, vecs[i]);
        check_expired_count("after load-on-final-tick", 1);

        // Reset mid-count at timer=2, then run to DONE and confirm start is ignored until load
        run_step(28, mk(1'b1,1'b0,0,1'b1,1'b0, 1,  5,1'b1,1'b0,1'b0));
        run_step(29, mk(1'b1,1'b0,0,1'b0,1'b0, 12, 2,1'b1,1'b0,1'b0));
        run_step(30, mk(1'b0,1'b0,0,1'b0,1'b0, 1,  3,1'b0,1'b0,1'b0));
        run_step(31, mk(1'b1,1'b0,0,1'b0,1'b0, 4,  3,1'b0,1'b0,1'b0));
        check_expired_count("after mid-count reset", 1);
        run_step(32, mk(1'b1,1'b0,0,1'b1,1'b0, 1,  3,1'b1,1'b0,1'b0));
        run_step(33, mk(1'b1,1'b0,0,1'b0,1'b0, 12, 0,1'b0,1'b1,1'b1));
        run_step(34, mk(1'b1,1'b0,0,1'b1,1'b0, 2,  0,1'b0,1'b0,1'b1));
        check_expired_count("after second expiry", 2);
        run_step(35, mk(1'b1,1'b1,7,1'b0,1'b0, 1,  7,1'b0,1'b0,1'b0));

        // Simultaneous start and pause in IDLE arms PAUSED; release + start runs
        run_step(36, mk(1'b1,1'b0,0,1'b1,1'b1, 1,  7,1'b0,1'b0,1'b0));
        run_step(37, mk(1'b1,1'b0,0,1'b0,1'b1, 5,  7,1'b0,1'b0,1'b0));
        run_step(38, mk(1'b1,1'b0,0,1'b1,1'b0, 1,  7,1'b1,1'b0,1'b0));
        run_step(39, mk(1'b1,1'b0,0,1'b0,1'b0, 4,  6,1'b1,1'b0,1'b0));
        check_expired_count("final", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
